// File: rtl/command_tag_allocator.sv
// Command tag allocator: hands out tags 1..TAG_COUNT to compute units and
// returns the stored CU ID when a tag comes back.
module command_tag_allocator #(
    parameter int TAG_COUNT   = 32,
    parameter int CU_ID_RANGE = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enabled_in,
    input  logic                         alloc_req_in,
    input  logic [CU_ID_RANGE-1:0]       alloc_cu_id_in,
    output logic                         alloc_valid_out,
    output logic [7:0]                   alloc_tag_out,
    input  logic                         rsp_valid_in,
    input  logic [7:0]                   rsp_tag_in,
    output logic                         rsp_valid_out,
    output logic [CU_ID_RANGE-1:0]       rsp_cu_id_out,
    output logic [$clog2(TAG_COUNT):0]   free_count_out,
    output logic                         tags_empty_out,
    output logic                         error_out
);

    localparam int CW = $clog2(TAG_COUNT) + 1;

    logic [TAG_COUNT-1:0]   r_in_use;
    logic [CU_ID_RANGE-1:0] r_cu_id [TAG_COUNT];
    logic                   r_alloc_valid;
    logic [7:0]             r_alloc_tag;
    logic                   r_rsp_valid;
    logic [CU_ID_RANGE-1:0] r_rsp_cu_id;
    logic [CW-1:0]          r_free_count;
    logic                   r_empty;
    logic                   r_error;

    logic [TAG_COUNT-1:0]   w_free_hit;
    logic [TAG_COUNT-1:0]   w_grant_hit;
    logic                   w_legal;
    logic [CU_ID_RANGE-1:0] w_rsp_id;
    logic                   w_any_free;
    logic [TAG_COUNT-1:0]   w_low_free;
    logic [7:0]             w_grant_tag;
    logic                   w_grant;
    logic [CW-1:0]          w_next_count;

    // Grant is chosen from the in-use state at the start of the cycle,
    // so a slot freed this cycle cannot be granted until the next one.
    always_comb begin
        w_free_hit  = '0;
        w_legal     = 1'b0;
        w_rsp_id    = '0;
        w_any_free  = 1'b0;
        w_low_free  = '0;
        w_grant_tag = '0;
        for (int i = 0; i < TAG_COUNT; i++) begin
            if (rsp_valid_in && rsp_tag_in == 8'(i + 1) && r_in_use[i]) begin
                w_free_hit[i] = 1'b1;
                w_legal       = 1'b1;
                w_rsp_id      = r_cu_id[i];
            end
        end
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (!r_in_use[i]) begin
                w_any_free  = 1'b1;
                w_low_free  = '0;
                w_low_free[i] = 1'b1;
                w_grant_tag = 8'(i + 1);
            end
        end
        w_grant      = alloc_req_in && enabled_in && w_any_free;
        w_grant_hit  = w_grant ? w_low_free : '0;
        w_next_count = r_free_count + CW'(w_legal) - CW'(w_grant);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_use      <= '0;
            for (int i = 0; i < TAG_COUNT; i++) begin
                r_cu_id[i] <= '0;
            end
            r_alloc_valid <= 1'b0;
            r_alloc_tag   <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_cu_id   <= '0;
            r_free_count  <= CW'(TAG_COUNT);
            r_empty       <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_in_use <= (r_in_use & ~w_free_hit) | w_grant_hit;
            for (int i = 0; i < TAG_COUNT; i++) begin
                if (w_grant_hit[i]) begin
                    r_cu_id[i] <= alloc_cu_id_in;
                end
            end
            r_alloc_valid <= w_grant;
            r_alloc_tag   <= w_grant ? w_grant_tag : 8'd0;
            r_rsp_valid   <= w_legal;
            r_rsp_cu_id   <= w_rsp_id;
            r_free_count  <= w_next_count;
            r_empty       <= (w_next_count == '0);
            r_error       <= r_error | (rsp_valid_in & ~w_legal);
        end
    end

    assign alloc_valid_out = r_alloc_valid;
    assign alloc_tag_out   = r_alloc_tag;
    assign rsp_valid_out   = r_rsp_valid;
    assign rsp_cu_id_out   = r_rsp_cu_id;
    assign free_count_out  = r_free_count;
    assign tags_empty_out  = r_empty;
    assign error_out       = r_error;

endmodule

// File: tb/tb_command_tag_allocator.sv
// Directed bench for command_tag_allocator with hand-computed expectations.
module tb_command_tag_allocator;

    logic       clock;
    logic       reset;
    logic       enabled_in;
    logic       alloc_req_in;
    logic [7:0] alloc_cu_id_in;
    logic       alloc_valid_out;
    logic [7:0] alloc_tag_out;
    logic       rsp_valid_in;
    logic [7:0] rsp_tag_in;
    logic       rsp_valid_out;
    logic [7:0] rsp_cu_id_out;
    logic [5:0] free_count_out;
    logic       tags_empty_out;
    logic       error_out;

    int n_pass;
    int n_total;

    command_tag_allocator #(
        .TAG_COUNT   (32),
        .CU_ID_RANGE (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enabled_in      (enabled_in),
        .alloc_req_in    (alloc_req_in),
        .alloc_cu_id_in  (alloc_cu_id_in),
        .alloc_valid_out (alloc_valid_out),
        .alloc_tag_out   (alloc_tag_out),
        .rsp_valid_in    (rsp_valid_in),
        .rsp_tag_in      (rsp_tag_in),
        .rsp_valid_out   (rsp_valid_out),
        .rsp_cu_id_out   (rsp_cu_id_out),
        .free_count_out  (free_count_out),
        .tags_empty_out  (tags_empty_out),
        .error_out       (error_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are
    // sampled 1 time unit after the following rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        reset          = 1'b1;
        enabled_in     = 1'b1;
        alloc_req_in   = 1'b0;
        alloc_cu_id_in = 8'h00;
        rsp_valid_in   = 1'b0;
        rsp_tag_in     = 8'h00;
        #1;
        chk("rst_alloc_valid", 32'(alloc_valid_out), 0);
        chk("rst_alloc_tag", 32'(alloc_tag_out), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_out), 0);
        chk("rst_rsp_id", 32'(rsp_cu_id_out), 0);
        chk("rst_count", 32'(free_count_out), 32);
        chk("rst_empty", 32'(tags_empty_out), 0);
        chk("rst_error", 32'(error_out), 0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_alloc_valid", 32'(alloc_valid_out), 0);
        chk("post_rst_rsp_valid", 32'(rsp_valid_out), 0);

        // single allocate then free
        alloc_req_in   = 1'b1;
        alloc_cu_id_in = 8'h05;
        step();
        chk("a1_valid", 32'(alloc_valid_out), 1);
        chk("a1_tag", 32'(alloc_tag_out), 1);
        chk("a1_count", 32'(free_count_out), 31);
        alloc_req_in = 1'b0;
        rsp_valid_in = 1'b1;
        rsp_tag_in   = 8'd1;
        step();
        chk("f1_alloc_valid", 32'(alloc_valid_out), 0);
        chk("f1_rsp_valid", 32'(rsp_valid_out), 1);
        chk("f1_rsp_id", 32'(rsp_cu_id_out), 5);
        chk("f1_count", 32'(free_count_out), 32);
        rsp_valid_in = 1'b0;
        step();
        chk("idle_rsp_valid", 32'(rsp_valid_out), 0);

        // fill the pool, cu id = tag value
        alloc_req_in = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            alloc_cu_id_in = 8'(k);
            step();
            chk("fill_valid", 32'(alloc_valid_out), 1);
            chk("fill_tag", 32'(alloc_tag_out), 32'(k));
        end
        chk("full_count", 32'(free_count_out), 0);
        chk("full_empty", 32'(tags_empty_out), 1);
        step();
        chk("over_valid", 32'(alloc_valid_out), 0);
        chk("over_tag", 32'(alloc_tag_out), 0);
        chk("over_count", 32'(free_count_out), 0);
        chk("over_empty", 32'(tags_empty_out), 1);
        chk("over_error", 32'(error_out), 0);

        // free and request together while full
        alloc_cu_id_in = 8'hAA;
        rsp_valid_in   = 1'b1;
        rsp_tag_in     = 8'd7;
        step();
        chk("same_alloc_valid", 32'(alloc_valid_out), 0);
        chk("same_rsp_valid", 32'(rsp_valid_out), 1);
        chk("same_rsp_id", 32'(rsp_cu_id_out), 7);
        chk("same_count", 32'(free_count_out), 1);
        chk("same_empty", 32'(tags_empty_out), 0);
        rsp_valid_in = 1'b0;
        step();
        chk("regrant_valid", 32'(alloc_valid_out), 1);
        chk("regrant_tag", 32'(alloc_tag_out), 7);
        chk("regrant_count", 32'(free_count_out), 0);
        chk("regrant_empty", 32'(tags_empty_out), 1);
        alloc_req_in = 1'b0;

        // illegal frees
        rsp_valid_in = 1'b1;
        rsp_tag_in   = 8'd0;
        step();
        chk("ill0_rsp_valid", 32'(rsp_valid_out), 0);
        chk("ill0_rsp_id", 32'(rsp_cu_id_out), 0);
        chk("ill0_error", 32'(error_out), 1);
        chk("ill0_count", 32'(free_count_out), 0);
        rsp_tag_in = 8'd40;
        step();
        chk("ill40_rsp_valid", 32'(rsp_valid_out), 0);
        chk("ill40_count", 32'(free_count_out), 0);
        rsp_tag_in = 8'd3;
        step();
        chk("free3_rsp_valid", 32'(rsp_valid_out), 1);
        chk("free3_rsp_id", 32'(rsp_cu_id_out), 3);
        chk("free3_count", 32'(free_count_out), 1);
        step();
        chk("ill3_rsp_valid", 32'(rsp_valid_out), 0);
        chk("ill3_rsp_id", 32'(rsp_cu_id_out), 0);
        chk("ill3_count", 32'(free_count_out), 1);
        rsp_valid_in = 1'b0;
        step();
        chk("err_sticky", 32'(error_out), 1);

        // disabled: request dropped, free still processed
        enabled_in   = 1'b0;
        alloc_req_in = 1'b1;
        rsp_valid_in = 1'b1;
        rsp_tag_in   = 8'd5;
        step();
        chk("dis_alloc_valid", 32'(alloc_valid_out), 0);
        chk("dis_rsp_valid", 32'(rsp_valid_out), 1);
        chk("dis_rsp_id", 32'(rsp_cu_id_out), 5);
        chk("dis_count", 32'(free_count_out), 2);
        enabled_in   = 1'b1;
        alloc_req_in = 1'b0;
        rsp_valid_in = 1'b0;

        // reset with outstanding tags
        reset = 1'b1;
        step();
        reset = 1'b0;
        alloc_req_in   = 1'b1;
        alloc_cu_id_in = 8'h11;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("r4_tag", 32'(alloc_tag_out), 32'(k));
        end
        alloc_req_in = 1'b0;
        step();
        chk("r4_count", 32'(free_count_out), 28);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(free_count_out), 32);
        chk("mid_rst_error", 32'(error_out), 0);
        chk("mid_rst_valid", 32'(alloc_valid_out), 0);
        step();
        reset = 1'b0;
        rsp_valid_in = 1'b1;
        rsp_tag_in   = 8'd2;
        step();
        chk("stale_rsp_valid", 32'(rsp_valid_out), 0);
        chk("stale_error", 32'(error_out), 1);
        chk("stale_count", 32'(free_count_out), 32);
        rsp_valid_in = 1'b0;
        step();
        chk("stale_sticky", 32'(error_out), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
